// File: rtl/wash_panel.sv
// Customer front panel for the washing-machine controller: collects coin credit,
// launches single/double washes, manages pause during the run and refunds credit.
module wash_panel #(
   parameter int unsigned CREDIT_W     = 4,
   parameter int unsigned MAX_CREDIT   = 15,
   parameter int unsigned PRICE_SINGLE = 1,
   parameter int unsigned PRICE_DOUBLE = 2,
   parameter int unsigned COIN_HOLD    = 80,
   parameter int unsigned HOLD_W       = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                coin_pulse,
   input  logic                start_btn,
   input  logic                cancel_btn,
   input  logic                pause_btn,
   input  logic                double_btn,
   input  logic                wash_done,
   output logic                coin_in,
   output logic                double_wash,
   output logic                timer_pause,
   output logic [CREDIT_W-1:0] credit,
   output logic                coin_reject,
   output logic                refund_pulse,
   output logic                busy,
   output logic                cycle_done
);

   localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(MAX_CREDIT);
   localparam logic [CREDIT_W-1:0] PRICE_S    = CREDIT_W'(PRICE_SINGLE);
   localparam logic [CREDIT_W-1:0] PRICE_D    = CREDIT_W'(PRICE_DOUBLE);
   localparam logic [HOLD_W-1:0]   HOLD_INIT  = HOLD_W'(COIN_HOLD - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_RUN    = 3'd2,
      S_DONE   = 3'd3,
      S_REFUND = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                sel_q, sel_d;
   logic                tpause_q, tpause_d;
   logic                coin_in_q, coin_in_d;
   logic                dbl_q, dbl_d;
   logic                reject_q, reject_d;
   logic                refund_q, refund_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                start_btn_q, cancel_btn_q, pause_btn_q, double_btn_q;

   logic                start_rise, cancel_rise, pause_rise, double_rise;
   logic [CREDIT_W-1:0] credit_eff;
   logic [CREDIT_W-1:0] price;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         credit_q     <= '0;
         hold_q       <= '0;
         sel_q        <= 1'b0;
         tpause_q     <= 1'b0;
         coin_in_q    <= 1'b0;
         dbl_q        <= 1'b0;
         reject_q     <= 1'b0;
         refund_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         start_btn_q  <= 1'b0;
         cancel_btn_q <= 1'b0;
         pause_btn_q  <= 1'b0;
         double_btn_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         credit_q     <= credit_d;
         hold_q       <= hold_d;
         sel_q        <= sel_d;
         tpause_q     <= tpause_d;
         coin_in_q    <= coin_in_d;
         dbl_q        <= dbl_d;
         reject_q     <= reject_d;
         refund_q     <= refund_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         start_btn_q  <= start_btn;
         cancel_btn_q <= cancel_btn;
         pause_btn_q  <= pause_btn;
         double_btn_q <= double_btn;
      end
   end

   // Next state, credit bookkeeping and registered-output next values.
   always_comb begin
      state_d     = state_q;
      credit_d    = credit_q;
      hold_d      = hold_q;
      sel_d       = sel_q;
      tpause_d    = tpause_q;
      reject_d    = 1'b0;
      refund_d    = 1'b0;
      done_d      = 1'b0;
      credit_eff  = credit_q;
      price       = PRICE_S;
      start_rise  = start_btn & ~start_btn_q;
      cancel_rise = cancel_btn & ~cancel_btn_q;
      pause_rise  = pause_btn & ~pause_btn_q;
      double_rise = double_btn & ~double_btn_q;

      unique case (state_q)
         S_IDLE: begin
            if (double_rise) sel_d = ~sel_q;
            // A coin in the same cycle as start counts toward the price check.
            if (coin_pulse) begin
               if (credit_q == CREDIT_MAX) reject_d = 1'b1;
               else credit_eff = credit_q + CREDIT_W'(1);
            end
            price    = sel_d ? PRICE_D : PRICE_S;
            credit_d = credit_eff;
            if (start_rise && (credit_eff >= price)) begin
               state_d  = S_LAUNCH;
               credit_d = credit_eff - price;
               hold_d   = HOLD_INIT;
            end else if (cancel_rise && (credit_eff != '0)) begin
               state_d = S_REFUND;
            end
         end
         S_LAUNCH: begin
            reject_d = coin_pulse;
            if (hold_q == '0) state_d = S_RUN;
            else hold_d = hold_q - HOLD_W'(1);
         end
         S_RUN: begin
            reject_d = coin_pulse;
            if (wash_done) begin
               state_d  = S_DONE;
               tpause_d = 1'b0;
               sel_d    = 1'b0;
               done_d   = 1'b1;
            end else if (pause_rise) begin
               tpause_d = ~tpause_q;
            end
         end
         S_DONE: begin
            reject_d = coin_pulse;
            state_d  = S_IDLE;
         end
         S_REFUND: begin
            refund_d = 1'b1;
            // An accepted coin here is returned by this pulse, so credit holds.
            if (coin_pulse && (credit_q != CREDIT_MAX)) begin
               credit_d = credit_q;
            end else begin
               reject_d = coin_pulse;
               credit_d = credit_q - CREDIT_W'(1);
            end
            if (credit_d == '0) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      coin_in_d = (state_d == S_LAUNCH);
      busy_d    = (state_d == S_LAUNCH) || (state_d == S_RUN);
      dbl_d     = sel_d;
   end

   assign coin_in      = coin_in_q;
   assign double_wash  = dbl_q;
   assign timer_pause  = tpause_q;
   assign credit       = credit_q;
   assign coin_reject  = reject_q;
   assign refund_pulse = refund_q;
   assign busy         = busy_q;
   assign cycle_done   = done_q;

endmodule

// File: tb/tb_wash_panel.sv
// Directed bench for wash_panel: a per-cycle behavioural model checked on every
// falling edge, plus hand-computed expectations along the directed scenarios.
module tb_wash_panel;

   localparam int MAXC  = 15;
   localparam int HOLD  = 80;
   localparam int P_IDLE = 0, P_LAUNCH = 1, P_RUN = 2, P_DONE = 3, P_REFUND = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       coin_pulse = 1'b0, start_btn = 1'b0, cancel_btn = 1'b0;
   logic       pause_btn = 1'b0, double_btn = 1'b0, wash_done = 1'b0;
   logic       coin_in, double_wash, timer_pause, coin_reject, refund_pulse, busy, cycle_done;
   logic [3:0] credit;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   wash_panel dut (
      .clk(clk), .rst(rst), .coin_pulse(coin_pulse), .start_btn(start_btn),
      .cancel_btn(cancel_btn), .pause_btn(pause_btn), .double_btn(double_btn),
      .wash_done(wash_done), .coin_in(coin_in), .double_wash(double_wash),
      .timer_pause(timer_pause), .credit(credit), .coin_reject(coin_reject),
      .refund_pulse(refund_pulse), .busy(busy), .cycle_done(cycle_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: phase, credit and remaining launch cycles.
   int phase = P_IDLE, m_credit = 0, launch_left = 0;
   bit m_sel = 0, m_pause = 0;
   bit p_start = 0, p_cancel = 0, p_pause = 0, p_double = 0;
   bit e_rej = 0, e_ref = 0, e_done = 0;

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            phase = P_IDLE; m_credit = 0; launch_left = 0; m_sel = 0; m_pause = 0;
            p_start = 0; p_cancel = 0; p_pause = 0; p_double = 0;
            e_rej = 0; e_ref = 0; e_done = 0;
         end else begin
            e_rej = 0; e_ref = 0; e_done = 0;
            case (phase)
               P_IDLE: begin
                  if (double_btn && !p_double) m_sel = !m_sel;
                  if (coin_pulse) begin
                     if (m_credit >= MAXC) e_rej = 1;
                     else m_credit = m_credit + 1;
                  end
                  if (start_btn && !p_start && m_credit >= (m_sel ? 2 : 1)) begin
                     m_credit    = m_credit - (m_sel ? 2 : 1);
                     phase       = P_LAUNCH;
                     launch_left = HOLD;
                  end else if (cancel_btn && !p_cancel && m_credit > 0) begin
                     phase = P_REFUND;
                  end
               end
               P_LAUNCH: begin
                  e_rej = coin_pulse;
                  launch_left = launch_left - 1;
                  if (launch_left == 0) phase = P_RUN;
               end
               P_RUN: begin
                  e_rej = coin_pulse;
                  if (wash_done) begin
                     phase = P_DONE; m_pause = 0; m_sel = 0; e_done = 1;
                  end else if (pause_btn && !p_pause) begin
                     m_pause = !m_pause;
                  end
               end
               P_DONE: begin
                  e_rej = coin_pulse;
                  phase = P_IDLE;
               end
               default: begin
                  e_ref = 1;
                  if (!(coin_pulse && m_credit < MAXC)) begin
                     e_rej    = coin_pulse;
                     m_credit = m_credit - 1;
                  end
                  if (m_credit == 0) phase = P_IDLE;
               end
            endcase
            p_start = start_btn; p_cancel = cancel_btn; p_pause = pause_btn; p_double = double_btn;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            chk("m_coin_in", coin_in, int'(phase == P_LAUNCH));
            chk("m_busy", busy, int'(phase == P_LAUNCH || phase == P_RUN));
            chk("m_double_wash", double_wash, int'(m_sel));
            chk("m_timer_pause", timer_pause, int'(m_pause));
            chk("m_credit", int'(credit), m_credit);
            chk("m_coin_reject", coin_reject, int'(e_rej));
            chk("m_refund_pulse", refund_pulse, int'(e_ref));
            chk("m_cycle_done", cycle_done, int'(e_done));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic coin1();
      coin_pulse = 1'b1; @(negedge clk); coin_pulse = 1'b0;
   endtask

   task automatic press_start();
      start_btn = 1'b1; @(negedge clk); start_btn = 1'b0;
   endtask

   task automatic press_cancel();
      cancel_btn = 1'b1; @(negedge clk); cancel_btn = 1'b0;
   endtask

   task automatic press_double();
      double_btn = 1'b1; @(negedge clk); double_btn = 1'b0;
   endtask

   task automatic press_pause();
      pause_btn = 1'b1; @(negedge clk); pause_btn = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      step(3);
      rst = 1'b0;
      cmp_en = 1'b1;
      chk("rst_coin_in", coin_in, 0);
      chk("rst_busy", busy, 0);
      chk("rst_credit", int'(credit), 0);
      chk("rst_double", double_wash, 0);
      chk("rst_refund", refund_pulse, 0);

      // Single wash: one coin, 80-cycle launch window, done after a long run.
      coin1();
      chk("single_credit_after_coin", int'(credit), 1);
      press_start();
      chk("single_coin_in_start", coin_in, 1);
      chk("single_busy_start", busy, 1);
      chk("single_credit_after_start", int'(credit), 0);
      cnt = 1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (coin_in) cnt++;
         else break;
      end
      chk("single_coin_in_len", cnt, 80);
      chk("single_busy_run", busy, 1);
      step(500);
      wash_done = 1'b1;
      step(1);
      chk("single_cycle_done", cycle_done, 1);
      chk("single_busy_done", busy, 0);
      chk("single_credit_done", int'(credit), 0);
      wash_done = 1'b0;
      step(1);
      chk("single_cycle_done_clear", cycle_done, 0);

      // Double wash with pause toggling and a rejected coin during the run.
      coin1(); coin1();
      chk("double_credit2", int'(credit), 2);
      press_double();
      chk("double_sel", double_wash, 1);
      press_start();
      chk("double_coin_in", coin_in, 1);
      chk("double_credit0", int'(credit), 0);
      chk("double_wash_launch", double_wash, 1);
      step(199);
      press_pause();
      chk("pause_on_200", timer_pause, 1);
      chk("double_wash_run", double_wash, 1);
      coin1();
      chk("run_coin_reject", coin_reject, 1);
      chk("run_coin_credit", int'(credit), 0);
      step(498);
      press_pause();
      chk("pause_off_700", timer_pause, 0);
      step(1);
      pause_btn = 1'b1;
      step(1);
      chk("pause_on_held", timer_pause, 1);
      step(1);
      wash_done = 1'b1;
      step(1);
      chk("done_pause_cleared", timer_pause, 0);
      chk("done_cycle_done", cycle_done, 1);
      chk("done_double_cleared", double_wash, 0);
      wash_done = 1'b0;
      pause_btn = 1'b0;
      step(2);

      // Double selected but only one coin: start must be ignored.
      press_double();
      coin1();
      press_start();
      chk("poor_coin_in", coin_in, 0);
      chk("poor_busy", busy, 0);
      chk("poor_credit", int'(credit), 1);
      step(1);
      chk("poor_coin_in_later", coin_in, 0);

      // Refund three coins.
      coin1(); coin1();
      chk("refund_credit3", int'(credit), 3);
      press_cancel();
      chk("refund_enter_credit", int'(credit), 3);
      chk("refund_enter_pulse", refund_pulse, 0);
      for (int k = 2; k >= 0; k--) begin
         step(1);
         chk("refund_pulse", refund_pulse, 1);
         chk("refund_credit", int'(credit), k);
      end
      step(1);
      chk("refund_end_pulse", refund_pulse, 0);
      press_double();
      chk("sel_cleared", double_wash, 0);

      // Saturation at 15 and rejection of the 16th coin.
      repeat (15) coin1();
      chk("sat_credit15", int'(credit), 15);
      chk("sat_no_reject", coin_reject, 0);
      coin1();
      chk("sat_reject16", coin_reject, 1);
      chk("sat_credit_hold", int'(credit), 15);
      press_cancel();
      step(16);
      chk("sat_refund_all", int'(credit), 0);
      chk("sat_refund_end", refund_pulse, 0);

      // Coin and start together launch from zero credit; reset mid-launch.
      coin_pulse = 1'b1; start_btn = 1'b1;
      step(1);
      coin_pulse = 1'b0; start_btn = 1'b0;
      chk("coinstart_coin_in", coin_in, 1);
      chk("coinstart_credit", int'(credit), 0);
      step(39);
      rst = 1'b1;
      step(1);
      chk("midrst_coin_in", coin_in, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_credit", int'(credit), 0);
      rst = 1'b0;
      press_start();
      chk("nocredit_coin_in", coin_in, 0);
      step(2);
      chk("nocredit_busy", busy, 0);

      // Stale wash_done already high when the run begins.
      wash_done = 1'b1; coin_pulse = 1'b1; start_btn = 1'b1;
      step(1);
      coin_pulse = 1'b0; start_btn = 1'b0;
      cnt = 0;
      while (!cycle_done && cnt < 200) begin
         step(1);
         cnt++;
      end
      chk("stale_done_latency", cnt, 81);
      wash_done = 1'b0;
      step(5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
